// File: rtl/fpu_pkg.sv
// Shared FPU definitions: floating-point format encodings and their bit widths.
package fpu_pkg;

  localparam logic [1:0] FMT_S = 2'b00;
  localparam logic [1:0] FMT_D = 2'b01;
  localparam logic [1:0] FMT_H = 2'b10;
  localparam logic [1:0] FMT_Q = 2'b11;

  // Number of significant bits carried by a value of the given format.
  function automatic int unsigned fmt_width(input logic [1:0] fmt);
    case (fmt)
      FMT_H:   return 32'd16;
      FMT_S:   return 32'd32;
      FMT_D:   return 32'd64;
      default: return 32'd128;
    endcase
  endfunction

endpackage

// File: rtl/fnanbox.sv
// NaN-boxing of a right-justified result: bits above the format width are forced to one.
module fnanbox
  import fpu_pkg::*;
#(
  parameter int unsigned FLEN = 64
) (
  input  logic [FLEN-1:0] data,
  input  logic [1:0]      fmt,
  output logic [FLEN-1:0] boxed
);

  // A format wider than FLEN leaves every bit below the width, so data passes unboxed.
  always_comb begin
    boxed = '1;
    for (int unsigned i = 0; i < FLEN; i++) begin
      if (i < fmt_width(fmt)) boxed[i] = data[i];
    end
  end

endmodule

// File: rtl/fregfile_sb.sv
// FPU register file: shared write port (pipeline over long unit), write-through reads,
// NaN-boxed writes and a busy scoreboard for outstanding long-latency destinations.
module fregfile_sb
  import fpu_pkg::*;
#(
  parameter int unsigned FLEN  = 64,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pw_en,
  input  logic [$clog2(NREGS)-1:0]    pw_addr,
  input  logic [FLEN-1:0]             pw_data,
  input  logic [1:0]                  pw_fmt,
  input  logic                        lw_valid,
  output logic                        lw_ready,
  input  logic [$clog2(NREGS)-1:0]    lw_addr,
  input  logic [FLEN-1:0]             lw_data,
  input  logic [1:0]                  lw_fmt,
  input  logic                        iss_en,
  input  logic [$clog2(NREGS)-1:0]    iss_addr,
  input  logic [NRD*$clog2(NREGS)-1:0] ra,
  output logic [NRD*FLEN-1:0]         rd,
  output logic [NRD-1:0]              rbusy,
  output logic [NREGS-1:0]            busy_vec
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [FLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             lw_fire;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [FLEN-1:0]  wdata;
  logic [1:0]       wfmt;
  logic [FLEN-1:0]  wboxed;

  // Pipeline writeback owns the port whenever it writes; the long unit waits.
  assign lw_ready = !reset && !pw_en;
  assign lw_fire  = lw_valid && lw_ready;
  assign we       = !reset && (pw_en || lw_fire);
  assign waddr    = pw_en ? pw_addr : lw_addr;
  assign wdata    = pw_en ? pw_data : lw_data;
  assign wfmt     = pw_en ? pw_fmt  : lw_fmt;

  fnanbox #(.FLEN(FLEN)) u_box (
    .data  (wdata),
    .fmt   (wfmt),
    .boxed (wboxed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wboxed;
    end
  end

  // A same-cycle issue is younger than the completing op, so set wins over clear.
  always_comb begin
    busy_next = busy;
    if (lw_fire) busy_next[lw_addr] = 1'b0;
    if (iss_en)  busy_next[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra_k;
    assign ra_k = ra[k*AW +: AW];
    assign rd[k*FLEN +: FLEN] = (we && waddr == ra_k) ? wboxed : regs[ra_k];
    assign rbusy[k] = busy[ra_k] && !(lw_fire && lw_addr == ra_k);
  end

  a_waw: assert property (@(posedge clk) disable iff (reset)
    iss_en |-> (!busy[iss_addr] || (lw_fire && lw_addr == iss_addr)));

  a_pw_busy: assert property (@(posedge clk) disable iff (reset)
    pw_en |-> !busy[pw_addr]);

  a_fmt: assert property (@(posedge clk) disable iff (reset)
    we |-> (fmt_width(wfmt) <= FLEN));

endmodule

// File: tb/tb_fregfile_sb.sv
// Randomized bench for fregfile_sb with directed scenarios and a behavioural register-file model.
module tb_fregfile_sb;
  import fpu_pkg::*;

  localparam int unsigned FLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 3;
  localparam int unsigned AW    = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 pw_en;
  logic [AW-1:0]        pw_addr;
  logic [FLEN-1:0]      pw_data;
  logic [1:0]           pw_fmt;
  logic                 lw_valid;
  logic                 lw_ready;
  logic [AW-1:0]        lw_addr;
  logic [FLEN-1:0]      lw_data;
  logic [1:0]           lw_fmt;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*FLEN-1:0]  rd;
  logic [NRD-1:0]       rbusy;
  logic [NREGS-1:0]     busy_vec;

  always #5 clk = ~clk;

  fregfile_sb #(.FLEN(FLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .reset(reset),
    .pw_en(pw_en), .pw_addr(pw_addr), .pw_data(pw_data), .pw_fmt(pw_fmt),
    .lw_valid(lw_valid), .lw_ready(lw_ready), .lw_addr(lw_addr), .lw_data(lw_data), .lw_fmt(lw_fmt),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .ra(ra), .rd(rd), .rbusy(rbusy), .busy_vec(busy_vec)
  );

  logic [FLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy;
  logic             m_fire;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural boxing rule: upper bits of a narrow value read as all ones.
  function automatic logic [FLEN-1:0] box(input logic [FLEN-1:0] d, input logic [1:0] f);
    case (f)
      2'b00:   return {32'hFFFF_FFFF, d[31:0]};
      2'b10:   return {48'hFFFF_FFFF_FFFF, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [AW-1:0] pick(input logic want_busy);
    logic [AW-1:0] a;
    for (int t = 0; t < 200; t++) begin
      a = AW'($urandom_range(0, NREGS-1));
      if (m_busy[a] == want_busy) return a;
    end
    return a;
  endfunction

  task automatic set_ra(input int a0, input int a1, input int a2);
    ra = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  // One clock: check combinational outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic          wr;
    logic [AW-1:0] wa;
    logic [FLEN-1:0] wv;
    logic          fire;
    logic [AW-1:0] a;
    wr = 1'b0; wa = '0; wv = '0;
    fire = !reset && !pw_en && lw_valid;
    if (!reset && pw_en) begin
      wr = 1'b1; wa = pw_addr; wv = box(pw_data, pw_fmt);
    end else if (fire) begin
      wr = 1'b1; wa = lw_addr; wv = box(lw_data, lw_fmt);
    end
    @(negedge clk);
    check("lw_ready", 128'(lw_ready), 128'(!reset && !pw_en));
    check("busy_vec", 128'(busy_vec), 128'(m_busy));
    for (int k = 0; k < int'(NRD); k++) begin
      a = ra[k*AW +: AW];
      check($sformatf("rd%0d", k), 128'(rd[k*FLEN +: FLEN]),
            128'((wr && wa == a) ? wv : m_regs[a]));
      check($sformatf("rbusy%0d", k), 128'(rbusy[k]),
            128'(m_busy[a] && !(fire && lw_addr == a)));
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      if (wr) m_regs[wa] = wv;
      if (fire) m_busy[lw_addr] = 1'b0;
      if (iss_en) m_busy[iss_addr] = 1'b1;
    end
    m_fire = fire && !reset;
    #1;
  endtask

  task automatic idle();
    pw_en = 1'b0; lw_valid = 1'b0; iss_en = 1'b0;
  endtask

  initial begin
    logic pend;
    reset = 1'b1; idle();
    pw_addr = '0; pw_data = '0; pw_fmt = FMT_D;
    lw_addr = '0; lw_data = '0; lw_fmt = FMT_D; iss_addr = '0;
    set_ra(0, 1, 2);
    for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
    m_busy = '0; m_fire = 1'b0;
    @(posedge clk); #1;
    cycle(); cycle();
    reset = 1'b0;
    #1;
    check("rst_busy", 128'(busy_vec), 128'(0));

    // Boxing of single, double and half results
    pw_en = 1'b1; pw_addr = 5'd5; pw_fmt = FMT_S; pw_data = 64'h3F80_0000; cycle();
    pw_addr = 5'd6; pw_fmt = FMT_D; pw_data = 64'h4000_0000_0000_0000; cycle();
    pw_addr = 5'd8; pw_fmt = FMT_H; pw_data = 64'hDEAD_BEEF_CAFE_3C00; cycle();
    idle(); set_ra(5, 6, 8); #1;
    check("box_s", 128'(rd[63:0]), 128'(64'hFFFF_FFFF_3F80_0000));
    check("box_d", 128'(rd[127:64]), 128'(64'h4000_0000_0000_0000));
    check("box_h", 128'(rd[191:128]), 128'(64'hFFFF_FFFF_FFFF_3C00));
    cycle();

    // Write-through bypass
    pw_en = 1'b1; pw_addr = 5'd7; pw_fmt = FMT_D; pw_data = 64'hAAAA; set_ra(7, 7, 0); cycle();
    idle(); #1;
    check("byp_prior", 128'(rd[63:0]), 128'(64'hAAAA));
    pw_en = 1'b1; pw_data = 64'h1234; #1;
    check("byp_same", 128'(rd[63:0]), 128'(64'h1234));
    cycle();

    // Arbitration: long unit stalled behind two pipeline writes
    lw_valid = 1'b1; lw_addr = 5'd3; lw_fmt = FMT_D; lw_data = 64'h0123_4567_89AB_CDEF;
    pw_en = 1'b1; pw_fmt = FMT_D; pw_addr = 5'd10; pw_data = 64'h10; set_ra(3, 10, 11); #1;
    check("arb_rdy0", 128'(lw_ready), 128'(0));
    cycle();
    check("arb_fire0", 128'(m_fire), 128'(0));
    pw_addr = 5'd11; pw_data = 64'h11; cycle();
    check("arb_fire1", 128'(m_fire), 128'(0));
    pw_en = 1'b0; #1;
    check("arb_rdy2", 128'(lw_ready), 128'(1));
    cycle();
    check("arb_fire2", 128'(m_fire), 128'(1));
    idle(); #1;
    check("arb_r3", 128'(rd[63:0]), 128'(64'h0123_4567_89AB_CDEF));
    check("arb_r10", 128'(rd[127:64]), 128'(64'h10));
    check("arb_r11", 128'(rd[191:128]), 128'(64'h11));

    // Scoreboard set and clear
    iss_en = 1'b1; iss_addr = 5'd9; set_ra(9, 9, 9); cycle();
    idle(); #1;
    check("sb_set", 128'(busy_vec[9]), 128'(1));
    check("sb_rbusy", 128'(rbusy[0]), 128'(1));
    lw_valid = 1'b1; lw_addr = 5'd9; lw_fmt = FMT_S; lw_data = 64'h4049_0FDB; #1;
    check("sb_rbusy_clr", 128'(rbusy[0]), 128'(0));
    check("sb_byp", 128'(rd[63:0]), 128'(64'hFFFF_FFFF_4049_0FDB));
    cycle();
    idle(); #1;
    check("sb_clr", 128'(busy_vec[9]), 128'(0));

    // Set/clear collision on r4
    iss_en = 1'b1; iss_addr = 5'd4; set_ra(4, 0, 1); cycle();
    lw_valid = 1'b1; lw_addr = 5'd4; lw_fmt = FMT_D; lw_data = 64'h5555_AAAA_5555_AAAA; cycle();
    idle(); #1;
    check("col_busy", 128'(busy_vec[4]), 128'(1));
    check("col_data", 128'(rd[63:0]), 128'(64'h5555_AAAA_5555_AAAA));

    // Random traffic under the hazard rules the surrounding pipeline guarantees
    pend = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      pw_en = ($urandom_range(0, 2) == 0);
      pw_addr = pick(1'b0);
      pw_fmt = 2'($urandom_range(0, 2));
      pw_data = {$urandom, $urandom};
      if (!pend && |m_busy && $urandom_range(0, 2) == 0) begin
        pend = 1'b1;
        lw_addr = pick(1'b1);
        lw_fmt = 2'($urandom_range(0, 2));
        lw_data = {$urandom, $urandom};
      end
      lw_valid = pend;
      iss_en = ($urandom_range(0, 3) == 0) && ($countones(m_busy) < 8);
      iss_addr = pick(1'b0);
      if (pend && !pw_en && $urandom_range(0, 5) == 0) begin
        iss_en = 1'b1; iss_addr = lw_addr;
      end
      ra = {AW'($urandom), AW'($urandom), AW'($urandom)};
      cycle();
      if (m_fire) pend = 1'b0;
    end

    // Reset with writes pending: writes dropped, everything clears
    pw_en = 1'b1; pw_addr = pick(1'b0); pw_data = 64'hFFFF; lw_valid = 1'b1; iss_en = 1'b0;
    reset = 1'b1; #1;
    check("rst_rdy", 128'(lw_ready), 128'(0));
    cycle();
    reset = 1'b0; idle(); #1;
    check("rst_busy2", 128'(busy_vec), 128'(0));
    for (int a = 0; a < int'(NREGS); a += 3) begin
      set_ra(a, (a + 1) % int'(NREGS), (a + 2) % int'(NREGS)); #1;
      check($sformatf("rst_rd_%0d", a), 128'(rd), 128'(0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fregfile_sb.md
Name: fregfile_sb

Overview:
Parametrised next-generation FPU register file with NRD combinational read ports, write-through bypass and NaN-boxing of narrow results. One physical write port is shared by two writers, with arbitration: the in-order pipeline writeback and a long-latency unit (FDIV/FSQRT) writeback using a valid/ready handshake. A per-register busy scoreboard tracks outstanding long-latency destinations so the hazard unit can stall dependent reads. Sits in the FPU between the decode/hazard logic and the execute units.

Parameters:
FLEN, 64, register width in bits; legal values 32, 64, 128.
NREGS, 32, number of registers; power of 2, 2..32.
NRD, 3, number of read ports, 1..4.
AW, $clog2(NREGS), address width (derived, not overridden).

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high.
pw_en  in  1  pipeline writeback enable.
pw_addr  in  AW  pipeline writeback address.
pw_data  in  FLEN  pipeline writeback data, right-justified.
pw_fmt  in  2  format of pw_data: 00 single, 01 double, 10 half, 11 quad.
lw_valid  in  1  long-unit result valid.
lw_ready  out  1  long-unit result accepted this cycle.
lw_addr  in  AW  long-unit destination.
lw_data  in  FLEN  long-unit result, right-justified.
lw_fmt  in  2  format of lw_data.
iss_en  in  1  long-latency op issued; marks destination busy.
iss_addr  in  AW  destination of issued op.
ra  in  NRD*AW  packed read addresses; port k = ra[k*AW +: AW].
rd  out  NRD*FLEN  packed read data.
rbusy  out  NRD  busy bit of each read address, bypass-adjusted.
busy_vec  out  NREGS  raw scoreboard state.

Behaviour:
- Reset (sync, active-high): all registers 0, busy_vec 0. During reset, lw_ready=0 and writes are ignored. Reset mid long-op drops the outstanding busy entry; the unit is flushed externally.
- Arbitration: lw_ready = !reset && !pw_en. Pipeline has priority. The long write commits when lw_valid && lw_ready. lw_valid must stay high, with stable addr/data, until accepted.
- Write select: W = pipeline if pw_en, else long if lw_valid&&lw_ready. At most one array write per cycle.
- NaN-boxing: width w = 16/32/64/128 for fmt 10/00/01/11. Written value = {ones(FLEN-w), data[w-1:0]} when w<FLEN, else data[FLEN-1:0]. fmt with w>FLEN is illegal; the assertion fires and the data is written unboxed.
- Read: rd port k = register ra_k, combinational. If a write commits this cycle to ra_k, the boxed write value is returned instead (write-through bypass, zero-cycle). Replaces the old negedge-write scheme.
- Scoreboard, next-state per register i:
  - set if iss_en && iss_addr==i;
  - clear if long write commits to i;
  - set and clear on the same i in the same cycle: set wins (new issue is younger).
  - iss_en to an already-busy register is illegal (WAW); assertion fires and busy stays 1.
  - Pipeline writes never change busy.
- rbusy[k] = busy[ra_k] && !(long write commits to ra_k this cycle). Same-cycle issue is not visible until the next cycle.
- Pipeline write to a busy register: data written, busy unchanged. The hazard unit must prevent this; an assertion flags it.
- Latency: write visible to reads the same cycle (bypass) and thereafter from the array. Busy set visible the next cycle.
- No x-propagation: out-of-range addresses (NREGS<32 with AW-bit inputs) cannot occur by construction.

Decomposition:
- fpu_pkg holds: fmt encoding constants (FMT_S=2'b00, FMT_D=2'b01, FMT_H=2'b10, FMT_Q=2'b11) and function fmt_width(fmt).
- Sub-module fnanbox: combinational boxing, params FLEN; in data, fmt; out boxed. Instanced once on the selected write data, after the mux.
- Scoreboard, arbitration and array stay in fregfile_sb.

Test Plan:
- Reset: assert reset 1 cycle after random writes -> all rd=0, busy_vec=0, lw_ready=0 during reset.
- Boxing (FLEN=64): pw_en, addr 5, fmt S, data 0x3F800000 -> rd of r5 = 0xFFFFFFFF3F800000. fmt D, data 0x4000000000000000 -> stored unchanged.
- Bypass: same-cycle pw write r7=0x1234 with ra0=7 -> rd0=0x1234 that cycle. Prior value returned the cycle before.
- Arbitration: lw_valid with lw_addr 3 held for 3 cycles while pw_en=1 for 2 cycles -> lw_ready low for 2 cycles, r3 written on cycle 3, pipeline writes intact.
- Scoreboard: iss_en r9 -> busy[9]=1 next cycle, rbusy=1 for ra=9. Long write to r9 accepted -> rbusy=0 that cycle, busy[9]=0 next.
- Set/clear collision: long write to r4 and iss_en r4 in the same cycle -> r4 holds the new data, busy[4]=1 afterwards.
